ftwiddle_gen: RTL

- Parametrised, pipelined twiddle-factor generator for the FFT/IFFT datapath. Produces W_N^k = cos(2πk/N) − j·sin(2πk/N) for any LOG2N. Conjugates the output for IFFT.
- Stores only one octant (N/8+1 entries) and rebuilds the full circle using octant and quadrant symmetry.
- Two request sources:
  - single-index lookup;
  - a built-in stride sweep engine that streams one twiddle per cycle for a butterfly stage.
- Sits between the FFT stage controller and the complex multipliers.

---
 rtl/fft_tw_pkg.sv | 22 ++
 rtl/ftwiddle_oct_rom.sv | 72 +++++++
 rtl/ftwiddle_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_tw_pkg.sv
// Shared definitions for the twiddle-factor generator: quadrant codes,
// the sweep FSM state type and the octant table depth helper.
package fft_tw_pkg;

    // Quadrant of the index k (its two top bits)
    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    // Sweep engine states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } tw_state_e;

    // One octant plus its closing point: j = 0 .. N/8
    function automatic int twiddle_octant_depth(input int log2n);
        return (1 << (log2n - 3)) + 1;
    endfunction

endpackage

// File: rtl/ftwiddle_oct_rom.sv
// Synchronous octant ROM. Each word is {C[j], S[j]} with
// C[j] = round(2^FRAC*cos(2*pi*j/N)) and S[j] = round(2^FRAC*sin(2*pi*j/N)).
// The table is built at elaboration time with integer-only arithmetic.
module ftwiddle_oct_rom
    import fft_tw_pkg::*;
#(
    parameter int    LOG2N      = 10,
    parameter int    MULT_WIDTH = 18,
    parameter int    FRAC_BITS  = 16,
    parameter string TW_FILE    = "twiddle_oct_1024_18.hex"
) (
    input  logic                        clk,
    input  logic                        en,
    input  logic [LOG2N-3:0]            addr,
    output logic [2*MULT_WIDTH-1:0]     data
);

    localparam int DEPTH = twiddle_octant_depth(LOG2N);
    localparam int DW    = 2 * MULT_WIDTH;

    // 2*pi in unsigned Q60 (hex expansion of pi, doubled and truncated)
    localparam logic [63:0] TWO_PI_Q60 = 64'h6487ED5110B4611A;

    // Taylor series in Q60 with 128-bit intermediates; terms are
    // accumulated by sign into separate positive/negative sums so the
    // whole computation stays unsigned. The angle never exceeds pi/4.
    function automatic logic [DW-1:0] oct_word(input int j);
        logic [127:0] theta;
        logic [127:0] term;
        logic [127:0] c_pos;
        logic [127:0] c_neg;
        logic [127:0] s_pos;
        logic [127:0] s_neg;
        logic [127:0] half;
        logic [127:0] c_fix;
        logic [127:0] s_fix;
        theta = (128'(TWO_PI_Q60) * 128'(j)) >> LOG2N;
        term  = 128'(1) << 60;
        c_pos = term;
        c_neg = '0;
        s_pos = '0;
        s_neg = '0;
        for (int k = 1; k <= 24; k++) begin
            term = ((term * theta) >> 60) / 128'(k);
            case (k % 4)
                0:       c_pos = c_pos + term;
                1:       s_pos = s_pos + term;
                2:       c_neg = c_neg + term;
                default: s_neg = s_neg + term;
            endcase
        end
        half  = 128'(1) << (59 - FRAC_BITS);
        c_fix = (c_pos - c_neg + half) >> (60 - FRAC_BITS);
        s_fix = (s_pos - s_neg + half) >> (60 - FRAC_BITS);
        return {MULT_WIDTH'(c_fix), MULT_WIDTH'(s_fix)};
    endfunction

    logic [DW-1:0] mem [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        localparam logic [DW-1:0] WORD = oct_word(g);
        assign mem[g] = WORD;
    end

    // Registered read; holds its word while the pipeline is frozen
    always_ff @(posedge clk) begin
        if (en) begin
            data <= mem[addr];
        end
    end

endmodule

// File: rtl/ftwiddle_gen.sv
// Pipelined twiddle-factor generator W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N),
// conjugated for the inverse transform. One octant is stored; the full
// circle is rebuilt by octant folding and a quadrant map.
//
// Request semantics: a request is taken on a rising edge only when rst=0,
// i_stall=0 and the sweep engine is idle (o_busy=0). i_start with a nonzero
// i_len has priority over i_valid; everything else is dropped silently, there
// is no ready/back-pressure signal. Results appear exactly three non-stalled
// edges after injection, with o_valid marking each sample.
module ftwiddle_gen
    import fft_tw_pkg::*;
#(
    parameter int    LOG2N      = 10,
    parameter int    MULT_WIDTH = 18,
    parameter int    FRAC_BITS  = 16,
    parameter string TW_FILE    = "twiddle_oct_1024_18.hex"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stall,
    input  logic                  i_inv,
    input  logic                  i_valid,
    input  logic [LOG2N-1:0]      i_idx,
    input  logic                  i_start,
    input  logic [LOG2N-1:0]      i_stride,
    input  logic [LOG2N:0]        i_len,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic                  o_last,
    output logic [MULT_WIDTH-1:0] o_re,
    output logic [MULT_WIDTH-1:0] o_im,
    output tw_state_e             o_state
);

    localparam int JW = LOG2N - 2;
    localparam int CW = LOG2N + 1;
    localparam int DW = 2 * MULT_WIDTH;
    localparam logic [JW-1:0] EIGHTH = JW'(1 << (LOG2N - 3));

    // Sweep engine registers
    tw_state_e        state;
    logic [LOG2N-1:0] acc;
    logic [CW-1:0]    m_cnt;
    logic [LOG2N-1:0] stride_q;
    logic [CW-1:0]    len_q;
    logic             inv_q;
    logic             sweep_last;

    // Injection into S1
    logic             inj_valid;
    logic [LOG2N-1:0] inj_idx;
    logic             inj_inv;
    logic             inj_last;
    logic [1:0]       inj_q;
    logic [JW-1:0]    inj_r;
    logic [JW-1:0]    inj_j;
    logic             inj_swap;

    // Pipeline stages
    logic             s1_valid;
    logic [JW-1:0]    s1_j;
    logic             s1_swap;
    logic [1:0]       s1_q;
    logic             s1_inv;
    logic             s1_last;
    logic             s2_valid;
    logic             s2_swap;
    logic [1:0]       s2_q;
    logic             s2_inv;
    logic             s2_last;
    logic [DW-1:0]    rom_data;

    // Output mapping
    logic [MULT_WIDTH-1:0] tab_c;
    logic [MULT_WIDTH-1:0] tab_s;
    logic [MULT_WIDTH-1:0] fold_c;
    logic [MULT_WIDTH-1:0] fold_s;
    logic [MULT_WIDTH-1:0] map_re;
    logic [MULT_WIDTH-1:0] map_im;

    assign sweep_last = (m_cnt == len_q - CW'(1));
    assign o_state    = state;

    // Source select: an active sweep owns the pipeline, otherwise a lookup
    // may enter unless a start is claiming this cycle.
    always_comb begin
        inj_valid = 1'b0;
        inj_idx   = '0;
        inj_inv   = 1'b0;
        inj_last  = 1'b0;
        if (state == ST_SWEEP) begin
            inj_valid = 1'b1;
            inj_idx   = acc;
            inj_inv   = inv_q;
            inj_last  = sweep_last;
        end else if (!(i_start && i_len != '0) && i_valid) begin
            inj_valid = 1'b1;
            inj_idx   = i_idx;
            inj_inv   = i_inv;
        end
    end

    // Octant fold: beyond N/8 mirror around N/8 and swap cos/sin roles
    assign inj_q    = inj_idx[LOG2N-1 -: 2];
    assign inj_r    = inj_idx[JW-1:0];
    assign inj_swap = (inj_r > EIGHTH);
    assign inj_j    = inj_swap ? (JW'(0) - inj_r) : inj_r;

    // Sweep FSM: latch stride/length at start, step the index each free cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            o_busy   <= 1'b0;
            acc      <= '0;
            m_cnt    <= '0;
            stride_q <= '0;
            len_q    <= '0;
            inv_q    <= 1'b0;
        end else if (!i_stall) begin
            case (state)
                ST_IDLE: begin
                    if (i_start && i_len != '0) begin
                        state    <= ST_SWEEP;
                        o_busy   <= 1'b1;
                        acc      <= '0;
                        m_cnt    <= '0;
                        stride_q <= i_stride;
                        len_q    <= i_len;
                        inv_q    <= i_inv;
                    end
                end
                default: begin
                    acc   <= acc + stride_q;
                    m_cnt <= m_cnt + CW'(1);
                    if (sweep_last) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    // S1: folded table address and the attributes that travel with it
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_j     <= '0;
            s1_swap  <= 1'b0;
            s1_q     <= '0;
            s1_inv   <= 1'b0;
            s1_last  <= 1'b0;
        end else if (!i_stall) begin
            s1_valid <= inj_valid;
            s1_j     <= inj_j;
            s1_swap  <= inj_swap;
            s1_q     <= inj_q;
            s1_inv   <= inj_inv;
            s1_last  <= inj_last;
        end
    end

    ftwiddle_oct_rom #(
        .LOG2N      (LOG2N),
        .MULT_WIDTH (MULT_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .TW_FILE    (TW_FILE)
    ) u_rom (
        .clk  (clk),
        .en   (!i_stall),
        .addr (s1_j),
        .data (rom_data)
    );

    // S2: attributes aligned with the registered ROM word
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_swap  <= 1'b0;
            s2_q     <= '0;
            s2_inv   <= 1'b0;
            s2_last  <= 1'b0;
        end else if (!i_stall) begin
            s2_valid <= s1_valid;
            s2_swap  <= s1_swap;
            s2_q     <= s1_q;
            s2_inv   <= s1_inv;
            s2_last  <= s1_last;
        end
    end

    assign tab_c = rom_data[DW-1 -: MULT_WIDTH];
    assign tab_s = rom_data[MULT_WIDTH-1:0];

    // Undo the fold swap, rotate into the quadrant, conjugate for IFFT.
    // Magnitudes never exceed 2^FRAC, so negation cannot overflow.
    always_comb begin
        fold_c = s2_swap ? tab_s : tab_c;
        fold_s = s2_swap ? tab_c : tab_s;
        case (s2_q)
            QUAD_0: begin
                map_re = fold_c;
                map_im = -fold_s;
            end
            QUAD_1: begin
                map_re = -fold_s;
                map_im = -fold_c;
            end
            QUAD_2: begin
                map_re = -fold_c;
                map_im = fold_s;
            end
            default: begin
                map_re = fold_s;
                map_im = fold_c;
            end
        endcase
        if (s2_inv) begin
            map_im = -map_im;
        end
    end

    // S3: registered outputs; data only moves with a valid sample
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_re    <= '0;
            o_im    <= '0;
        end else if (!i_stall) begin
            o_valid <= s2_valid;
            o_last  <= s2_valid && s2_last;
            if (s2_valid) begin
                o_re <= map_re;
                o_im <= map_im;
            end
        end
    end

endmodule
